ldm_scan: RTL and testbench

LDM_SCAN -- requirements
Module: ldm_scan

---
 rtl/ldm_pkg.sv | 18 +
 rtl/ldm_scan_if.sv | 25 ++
 rtl/ldm_sclk_gen.sv | 41 ++++
 rtl/ldm_scan.sv | 115 +++++++++++
 tb/tb_ldm_scan.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ldm_pkg.sv
// Shared constants and FSM state type for the LED dot-matrix row scanner.
package ldm_pkg;

  localparam int unsigned LDM_ROWS   = 16;
  localparam int unsigned LDM_LINE_W = 16;
  localparam int unsigned ROW_W      = $clog2(LDM_ROWS);
  localparam int unsigned BIT_W      = $clog2(LDM_LINE_W);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StCapture,
    StShift,
    StLatch,
    StShow
  } ldm_state_e;

endpackage

// File: rtl/ldm_scan_if.sv
// Scanner-side bundle: line-buffer lookup plus the column/row panel drive.
interface ldm_scan_if;
  import ldm_pkg::*;

  logic                  enable;
  logic [ROW_W-1:0]      ldm_addr;
  logic [LDM_LINE_W-1:0] ldm_line_data;
  logic                  ldm_sdi;
  logic                  ldm_sclk;
  logic                  ldm_latch;
  logic                  ldm_oe_n;
  logic [ROW_W-1:0]      row_sel;
  logic                  frame_done;

  modport master (
    input  enable, ldm_line_data,
    output ldm_addr, ldm_sdi, ldm_sclk, ldm_latch, ldm_oe_n, row_sel, frame_done
  );

  modport slave (
    output enable, ldm_line_data,
    input  ldm_addr, ldm_sdi, ldm_sclk, ldm_latch, ldm_oe_n, row_sel, frame_done
  );

endinterface

// File: rtl/ldm_sclk_gen.sv
// Column shift-clock divider: SCLK low for the first half of each bit, high for the second.
module ldm_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_sclk,
  output logic o_bit_done
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);

  logic [DivW-1:0] r_div;
  logic [DivW-1:0] w_div_nxt;
  logic            r_sclk;

  always_comb begin
    w_div_nxt = '0;
    if (i_run && (r_div != DivLast)) begin
      w_div_nxt = r_div + 1'b1;
    end
  end

  // SCLK is registered from the next divider value so it lines up with r_div.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_sclk <= i_run && (w_div_nxt >= DivHalf);
    end
  end

  assign o_sclk     = r_sclk;
  assign o_bit_done = i_run && (r_div == DivLast);

endmodule

// File: rtl/ldm_scan.sv
// Row scanner: fetch a line, shift it out LSB first, latch it, then light the row for DWELL cycles.
module ldm_scan
  import ldm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DWELL   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  ldm_scan_if.master       io_ldm
);

  localparam int unsigned DwellW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL - 1);
  localparam logic [BIT_W-1:0]  BitLast   = BIT_W'(LDM_LINE_W - 1);
  localparam logic [ROW_W-1:0]  RowLast   = ROW_W'(LDM_ROWS - 1);

  ldm_state_e            r_state;
  logic [ROW_W-1:0]      r_row;
  logic [BIT_W-1:0]      r_bit;
  logic [DwellW-1:0]     r_dwell;
  logic [LDM_LINE_W-1:0] r_shift;
  logic [ROW_W-1:0]      r_addr;
  logic [ROW_W-1:0]      r_row_sel;
  logic                  r_latch;
  logic                  r_oe_n;
  logic                  r_frame_done;
  logic                  w_sclk;
  logic                  w_bit_done;

  ldm_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk        (clk),
    .rst        (rst),
    .i_run      (r_state == StShift),
    .o_sclk     (w_sclk),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_row        <= '0;
      r_bit        <= '0;
      r_dwell      <= '0;
      r_shift      <= '0;
      r_addr       <= '0;
      r_row_sel    <= '0;
      r_latch      <= 1'b0;
      r_oe_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_latch      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (io_ldm.enable) begin
            r_row   <= '0;
            r_addr  <= '0;
            r_state <= StAddr;
          end
        end
        StAddr: r_state <= StCapture;
        StCapture: begin
          r_shift <= io_ldm.ldm_line_data;
          r_bit   <= '0;
          r_state <= StShift;
        end
        StShift: begin
          if (w_bit_done) begin
            if (r_bit == BitLast) begin
              r_latch   <= 1'b1;
              r_row_sel <= r_row;
              r_state   <= StLatch;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= r_shift >> 1;
            end
          end
        end
        StLatch: begin
          r_oe_n  <= 1'b0;
          r_dwell <= '0;
          r_state <= StShow;
        end
        StShow: begin
          if (r_dwell == DwellLast) begin
            r_oe_n       <= 1'b1;
            r_row        <= r_row + 1'b1;
            r_frame_done <= (r_row == RowLast);
            if (io_ldm.enable) begin
              r_addr  <= r_row + 1'b1;
              r_state <= StAddr;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_ldm.ldm_addr   = r_addr;
  assign io_ldm.ldm_sdi    = r_shift[0];
  assign io_ldm.ldm_sclk   = w_sclk;
  assign io_ldm.ldm_latch  = r_latch;
  assign io_ldm.ldm_oe_n   = r_oe_n;
  assign io_ldm.row_sel    = r_row_sel;
  assign io_ldm.frame_done = r_frame_done;

endmodule

// File: tb/tb_ldm_scan.sv
// Scoreboard bench for ldm_scan: expected rows are queued by the stimulus, checked on each LATCH.
module tb_ldm_scan;
  import ldm_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DWELL   = 8;
  localparam int PERIOD  = 3 + 16 * CLK_DIV + DWELL;

  typedef struct packed {
    logic [3:0]  row;
    logic [15:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ldm_scan_if bus ();

  ldm_scan #(
    .CLK_DIV (CLK_DIV),
    .DWELL   (DWELL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_ldm (bus)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          mode = 0;
  logic        armed = 1'b0;
  int          cnt = 0;
  logic [15:0] noise = '0;
  logic        scr;
  longint      cyc = 0;
  longint      last_latch = -1;
  longint      fd_prev = -1;
  logic [15:0] word = '0;
  int          nrise = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_oe = 1'b1;
  int          show_len = 0;
  logic        show_abort = 1'b0;
  logic        show_ovl = 1'b0;
  logic [3:0]  last_row = '0;

  function automatic logic [15:0] line_val(int m, logic [3:0] a);
    case (m)
      0:       return 16'h0001 << a;
      1:       return 16'hA5C3;
      default: return 16'h3C96 ^ {a, a, a, a};
    endcase
  endfunction

  // Mode 2 scrambles the buffer output on every cycle except the ADDR/CAPTURE slots of a row.
  assign scr = (mode == 2) && armed && (cnt != 9) && (cnt != 10);
  assign bus.ldm_line_data = scr ? noise : line_val(mode, bus.ldm_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_addr"}, 32'(bus.ldm_addr), 0);
    check({pfx, "_row_sel"}, 32'(bus.row_sel), 0);
    check({pfx, "_sdi"}, 32'(bus.ldm_sdi), 0);
    check({pfx, "_sclk"}, 32'(bus.ldm_sclk), 0);
    check({pfx, "_latch"}, 32'(bus.ldm_latch), 0);
    check({pfx, "_oe_n"}, 32'(bus.ldm_oe_n), 1);
    check({pfx, "_frame_done"}, 32'(bus.frame_done), 0);
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) check("wait_empty_timeout", 32'(q.size()), 0);
  endtask

  task automatic push_rows(input int m, input int first, input int last);
    for (int r = first; r <= last; r++) begin
      q.push_back(exp_t'{row: r[3:0], word: line_val(m, r[3:0])});
    end
  endtask

  // Monitor: samples on the falling edge, checks each latched row against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (bus.ldm_sclk && !prev_sclk) begin
          if (nrise < 16) word[nrise] = bus.ldm_sdi;
          nrise++;
        end
        if (!bus.ldm_oe_n) begin
          show_len++;
          if (bus.ldm_latch || bus.ldm_sclk) show_ovl = 1'b1;
        end else if (show_len > 0) begin
          if (!show_abort) begin
            check("show_len", 32'(show_len), DWELL);
            check("show_overlap", 32'(show_ovl), 0);
          end
          show_len   = 0;
          show_ovl   = 1'b0;
          show_abort = 1'b0;
        end
        if (bus.ldm_latch) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_latch: latch on row_sel=%0d with no row expected",
                     bus.row_sel);
          end else begin
            e = q.pop_front();
            check("row_sel", 32'(bus.row_sel), 32'(e.row));
            check("shifted_word", 32'(word), 32'(e.word));
            check("sclk_rises", 32'(nrise), 16);
            check("latch_oe_n", 32'(bus.ldm_oe_n), 1);
          end
          if (last_latch >= 0) check("row_period", 32'(cyc - last_latch), PERIOD);
          last_latch = cyc;
          last_row   = bus.row_sel;
          nrise      = 0;
          word       = '0;
          cnt        = 0;
          armed      = 1'b1;
        end else begin
          cnt++;
        end
        if (bus.frame_done) begin
          check("fd_after_row15", 32'(last_row), 15);
          check("fd_after_show", 32'({prev_oe, bus.ldm_oe_n}), 32'b01);
          if (fd_prev >= 0) check("fd_period", 32'(cyc - fd_prev), 16 * PERIOD);
          fd_prev = cyc;
        end
        prev_sclk = bus.ldm_sclk;
        prev_oe   = bus.ldm_oe_n;
      end
      noise = 16'($urandom);
    end
  end

  initial begin
    bus.enable = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Two full frames of walking-one lines.
    mode = 0;
    push_rows(0, 0, 15);
    push_rows(0, 0, 15);
    last_latch = -1;
    fd_prev    = -1;
    bus.enable = 1'b1;
    wait_empty(3000);
    bus.enable = 1'b0;
    repeat (30) @(negedge clk);
    check("idle_oe_n", 32'(bus.ldm_oe_n), 1);
    check("idle_sclk", 32'(bus.ldm_sclk), 0);

    // Drop ENABLE during row 5 SHIFT; row 5 must still complete.
    push_rows(0, 0, 5);
    last_latch = -1;
    bus.enable = 1'b1;
    for (int i = 0; i < 1000 && !(bus.ldm_addr == 4'd5 && bus.ldm_sclk); i++) @(negedge clk);
    check("reached_row5_shift", 32'({bus.ldm_addr, bus.ldm_sclk}), 32'({4'd5, 1'b1}));
    bus.enable = 1'b0;
    wait_empty(500);
    repeat (30) @(negedge clk);
    check("drop_idle_oe_n", 32'(bus.ldm_oe_n), 1);
    check("drop_addr_hold", 32'(bus.ldm_addr), 5);

    // Restart from IDLE on row 0 with a fixed pattern.
    mode = 1;
    push_rows(1, 0, 0);
    last_latch = -1;
    bus.enable = 1'b1;
    @(negedge clk);
    check("restart_addr", 32'(bus.ldm_addr), 0);
    wait_empty(500);
    bus.enable = 1'b0;
    repeat (30) @(negedge clk);

    // Reset in the middle of row 9 SHOW.
    mode = 0;
    push_rows(0, 0, 9);
    last_latch = -1;
    bus.enable = 1'b1;
    wait_empty(1500);
    repeat (3) @(negedge clk);
    check("show_active", 32'(bus.ldm_oe_n), 0);
    @(posedge clk);
    #2;
    show_abort = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_vals("midshow_rst");
    push_rows(0, 0, 1);
    last_latch = -1;
    fd_prev    = -1;
    nrise      = 0;
    @(negedge clk);
    rst = 1'b0;
    wait_empty(500);
    bus.enable = 1'b0;
    repeat (30) @(negedge clk);

    // Buffer output scrambled outside CAPTURE; shifted data must match the captured line.
    mode  = 2;
    armed = 1'b0;
    push_rows(2, 0, 2);
    last_latch = -1;
    bus.enable = 1'b1;
    wait_empty(500);
    bus.enable = 1'b0;
    repeat (30) @(negedge clk);

    check("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
